// File: rtl/led_driver_pkg.sv
// led_driver_pkg: shared definitions for the seven-segment scan driver.
// Holds the active-low segment patterns, the one-cold anode enables, the
// cathode_n bit-order definition and a helper mapping a digit select to its
// anode enable.
package led_driver_pkg;

  // cathode_n bit order: bit 7 is the decimal point, bits 6..0 are g..a.
  typedef struct packed {
    logic       dp;
    logic [6:0] seg;  // {g,f,e,d,c,b,a}, active-low
  } cathode_t;

  localparam int  CATH_DP_BIT = 7;
  localparam logic DP_OFF     = 1'b1;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One-cold anode enables, digit 0 is the rightmost.
  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [7:0] CATHODE_OFF = 8'hFF;

  function automatic logic [3:0] anode_for_sel(input logic [1:0] sel);
    logic [3:0] an;
    case (sel)
      2'd0:    an = ANODE_D0;
      2'd1:    an = ANODE_D1;
      2'd2:    an = ANODE_D2;
      2'd3:    an = ANODE_D3;
      default: an = ANODE_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/led_driver_if.sv
// led_driver_if: display-side bundle of the seven-segment driver.
//   bcd_ip    [15:0] packed BCD value, digit 0 in [3:0]
//   anode_n   [3:0]  active-low digit enables
//   cathode_n [7:0]  active-low segments, {dp,g,f,e,d,c,b,a}
// master: value producer / display observer; slave: the driver itself.
interface led_driver_if;
  logic [15:0] bcd_ip;
  logic [3:0]  anode_n;
  logic [7:0]  cathode_n;

  modport master (output bcd_ip, input anode_n, input cathode_n);
  modport slave  (input bcd_ip, output anode_n, output cathode_n);
endinterface

// File: rtl/led_driver_bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-low seven-segment decoder.
//   bcd_i   [3:0] BCD digit; 10..15 decode to blank
//   seg_n_o [6:0] active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import led_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Segment lookup; non-BCD codes show nothing rather than garbage.
  always_comb begin
    seg_n_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_driver.sv
// led_driver: multiplexed driver for a 4-digit common-anode seven-segment
// display. Scans digits 0,1,2,3 holding each for DIGIT_CYCLES clocks.
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; display dark while asserted
//   bus.bcd_ip    packed BCD input, sampled every clock
//   bus.anode_n   registered active-low digit enable (one-cold)
//   bus.cathode_n registered active-low segments, dp always off
module led_driver
  import led_driver_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int DIGIT_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  led_driver_if.slave bus
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (CLK_FREQ_HZ <= 0 || DIGIT_CYCLES < 2 || DIGIT_CYCLES > 16777216) begin : g_param_check
    $error("led_driver: CLK_FREQ_HZ must be positive and DIGIT_CYCLES in 2..2^24");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             run_q, run_d;
  logic [3:0]       anode_q, anode_d;
  logic [7:0]       cathode_q, cathode_d;
  logic [3:0]       nibble_s;
  logic [6:0]       seg_n_s;
  cathode_t         cath_s;

  // Dwell counter and digit select. The first edge after reset only lights
  // digit 0 without advancing the counter, so digit 0 gets a full dwell too.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    run_d = 1'b1;
    if (!run_q) begin
      cnt_d = '0;
      sel_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Nibble mux driven by the next select so anode and segments move together.
  always_comb begin
    nibble_s = 4'h0;
    case (sel_d)
      2'd0:    nibble_s = bus.bcd_ip[3:0];
      2'd1:    nibble_s = bus.bcd_ip[7:4];
      2'd2:    nibble_s = bus.bcd_ip[11:8];
      2'd3:    nibble_s = bus.bcd_ip[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd_i   (nibble_s),
    .seg_n_o (seg_n_s)
  );

  // Assemble output next-state.
  always_comb begin
    cath_s.dp  = DP_OFF;
    cath_s.seg = seg_n_s;
    anode_d    = anode_for_sel(sel_d);
    cathode_d  = cath_s;
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      run_q     <= 1'b0;
      anode_q   <= ANODE_OFF;
      cathode_q <= CATHODE_OFF;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      run_q     <= run_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign bus.anode_n   = anode_q;
  assign bus.cathode_n = cathode_q;

endmodule

// File: tb/tb_led_driver.sv
// tb_led_driver: self-checking bench for led_driver with a short dwell.
module tb_led_driver;
  localparam int DC = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ca;
  } exp_t;

  typedef struct packed {
    logic [15:0] bcd;
    logic [7:0]  ca;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  led_driver_if bus_if ();

  led_driver #(.CLK_FREQ_HZ(100_000_000), .DIGIT_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;            // rising edges since reset release
  exp_t sb_q[$];
  vec_t vecs[16];
  logic [3:0] hist[$];

  function automatic logic [7:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] bcd, input int edge_k, input logic rst);
    exp_t e;
    int   sel;
    if (rst || edge_k == 0) begin
      e.an = 4'hF;
      e.ca = 8'hFF;
    end else begin
      sel  = ((edge_k - 1) / DC) % 4;
      e.an = 4'hF ^ (4'b0001 << sel);
      e.ca = seg_ref(bcd[sel*4 +: 4]);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: drive at negedge, push expectation, pop and compare after edge.
  task automatic step(input logic [15:0] bcd, input logic rst, input string name);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus_if.bcd_ip = bcd;
    if (rst) k = 0;
    else k++;
    sb_q.push_back(model(bcd, k, rst));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(name, {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, e.an, e.ca});
    if (!rst) begin
      check({name, "_onecold"}, {31'd0, ($countones(~bus_if.anode_n) == 1) && bus_if.cathode_n[7]}, 32'd1);
    end
  endtask

  // Assert reset between edges and confirm the outputs darken before the next edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    k = 0;
    #1;
    check(name, {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, 4'hF, 8'hFF});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = {16'h0000, 8'hC0};
    vecs[1]  = {16'h1111, 8'hF9};
    vecs[2]  = {16'h2222, 8'hA4};
    vecs[3]  = {16'h3333, 8'hB0};
    vecs[4]  = {16'h4444, 8'h99};
    vecs[5]  = {16'h5555, 8'h92};
    vecs[6]  = {16'h6666, 8'h82};
    vecs[7]  = {16'h7777, 8'hF8};
    vecs[8]  = {16'h8888, 8'h80};
    vecs[9]  = {16'h9999, 8'h90};
    vecs[10] = {16'hAAAA, 8'hFF};
    vecs[11] = {16'hBBBB, 8'hFF};
    vecs[12] = {16'hCCCC, 8'hFF};
    vecs[13] = {16'hDDDD, 8'hFF};
    vecs[14] = {16'hEEEE, 8'hFF};
    vecs[15] = {16'hFFFF, 8'hFF};
    bus_if.bcd_ip = 16'h9538;

    // Reset held: display dark throughout.
    for (int i = 0; i < 5; i++) step(16'h9538, 1'b1, "reset_hold");

    // Scan sequence over four frames plus a little.
    for (int i = 0; i < 4 * DC * 4 + 2; i++) begin
      step(16'h9538, 1'b0, "scan");
      hist.push_back(bus_if.anode_n);
    end
    begin
      int run;
      int runs;
      logic [3:0] order[$];
      logic [3:0] want[5];
      want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b1011;
      want[3] = 4'b0111; want[4] = 4'b1110;
      run = 1;
      runs = 0;
      order.push_back(hist[0]);
      for (int i = 1; i < hist.size(); i++) begin
        if (hist[i] == hist[i-1]) run++;
        else begin
          check("dwell_len", run, DC);
          runs++;
          order.push_back(hist[i]);
          run = 1;
        end
      end
      check("dwell_count", runs, 16);
      for (int j = 0; j < 5; j++) check("scan_order", {28'd0, order[j]}, {28'd0, want[j]});
    end

    // Async reset mid-scan.
    async_reset("async_dark");
    for (int i = 0; i < 3; i++) step(16'h9538, 1'b1, "reset_mid");

    // Decoder sweep from the vector table.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].bcd, 1'b0, "decode");
      check("decode_tbl", {24'd0, bus_if.cathode_n}, {24'd0, vecs[i].ca});
    end

    // Live update on digit 0: 8 -> 1 shows one cycle later, anode steady.
    step(16'h0000, 1'b1, "lu_reset");
    step(16'h0008, 1'b0, "lu_d0");
    step(16'h0008, 1'b0, "lu_d0");
    check("lu_before", {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, 4'b1110, 8'h80});
    step(16'h0001, 1'b0, "lu_after");
    check("lu_after_x", {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, 4'b1110, 8'hF9});

    // Mid-scan reset on digit 2, then full dwell on digit 0.
    step(16'h9538, 1'b1, "ms_reset");
    for (int i = 0; i < 2 * DC + 2; i++) step(16'h9538, 1'b0, "ms_run");
    check("ms_on_d2", {28'd0, bus_if.anode_n}, {28'd0, 4'b1011});
    async_reset("ms_dark");
    step(16'h9538, 1'b1, "ms_hold");
    for (int i = 0; i < DC; i++) begin
      step(16'h9538, 1'b0, "ms_resume");
      check("ms_d0_dwell", {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, 4'b1110, 8'h80});
    end
    step(16'h9538, 1'b0, "ms_next");
    check("ms_d1", {20'd0, bus_if.anode_n, bus_if.cathode_n}, {20'd0, 4'b1101, 8'hB0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_driver.md
# led_driver

Multiplexed driver for a 4-digit, common-anode seven-segment display with decimal points. It takes a 16-bit packed BCD value and scans the four digits in turn. For each digit it drives one active-low anode enable and the active-low segment pattern for that digit. It sits at the board edge, between the value-producing logic and the display pins.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: input clock frequency.
- `DIGIT_CYCLES`, default 100_000: clock cycles each digit stays lit (1 ms at 100 MHz). Legal range is 2 to 2^24.
- `clk` input, 1 bit: single system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `bcd_ip` input, 16 bits: four BCD digits. [3:0] is digit 0 (rightmost), [7:4] is digit 1, [11:8] is digit 2, [15:12] is digit 3 (leftmost).
- `anode_n` output, 4 bits: active-low digit enables. Bit k enables digit k.
- `cathode_n` output, 8 bits: active-low segments. Bit 7 is dp; bits 6..0 are g,f,e,d,c,b,a.

## Operation
- Internal state:
  - dwell counter `cnt`, width clog2(DIGIT_CYCLES);
  - 2-bit digit select `sel`.
- Each clock, `cnt` increments. When `cnt == DIGIT_CYCLES-1`, `cnt` wraps to 0 and `sel` increments mod 4 (3 wraps to 0).
- Scan order is digit 0, 1, 2, 3, 0, …
- Exactly one `anode_n` bit is low whenever not in reset:
  - sel 0 gives 4'b1110;
  - sel 1 gives 4'b1101;
  - sel 2 gives 4'b1011;
  - sel 3 gives 4'b0111.
- `cathode_n[7]` (dp) is always 1 (off).
- `cathode_n[6:0]` is the decode of the selected nibble, written as {g,f,e,d,c,b,a}, active-low:

| BCD | Pattern |
|-----|---------|
| 0 | 1000000 |
| 1 | 1111001 |
| 2 | 0100100 |
| 3 | 0110000 |
| 4 | 0011001 |
| 5 | 0010010 |
| 6 | 0000010 |
| 7 | 1111000 |
| 8 | 0000000 |
| 9 | 0010000 |
| 10–15 | 1111111 (blank) |

- `bcd_ip` is sampled every clock and is not latched per frame. A change takes effect on the currently lit digit one cycle later.
- There is no leading-zero blanking and no brightness control.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `cnt` = 0, `sel` = 0;
  - `anode_n` = 4'b1111 and `cathode_n` = 8'hFF, so the display is dark.
- `anode_n` and `cathode_n` are registered outputs, driven from the registered next-state of `sel` and from `bcd_ip`.
- First rising edge after reset release: `anode_n` = 4'b1110 and `cathode_n` = decode(`bcd_ip[3:0]`).
- Each digit is lit for exactly `DIGIT_CYCLES` clocks. A full frame is 4×`DIGIT_CYCLES` clocks, which is 4 ms and 250 Hz at the defaults.
- On a digit change, `anode_n` and `cathode_n` update on the same edge. No cycle shows the new anode with the old segment pattern.
- If reset is asserted mid-scan, outputs go dark immediately. After release, the scan restarts at digit 0 with a full dwell.

## Structure
- Shared package `led_driver_pkg` holds:
  - segment pattern constants SEG_0 … SEG_9 and SEG_BLANK;
  - anode one-cold constants;
  - the `cathode_n` bit-order definition.
- One sub-module, `bcd_to_seg`: a combinational 4-bit BCD to 7-bit active-low decoder, with blank for 10–15.
- The top level holds the counter, the select register, the nibble mux and the output registers.

## Test plan
- **Reset:**
  - stimulus: hold `reset` = 1 for several cycles, with `bcd_ip` = 16'h9538;
  - required: `anode_n` = 4'b1111 and `cathode_n` = 8'hFF throughout; an asynchronous assert between edges darkens outputs immediately.
- **Scan sequence:**
  - stimulus: `bcd_ip` = 16'h9538, `DIGIT_CYCLES` = 100_000, clock 100 MHz, run 5 ms after reset;
  - required: digit 0 shows 1110/8'h80, digit 1 shows 1101/8'hB0, digit 2 shows 1011/8'h92, digit 3 shows 0111/8'h90, then digit 0 again shows 1110/8'h80;
  - required: each state persists exactly 100_000 cycles.
- **Decoder sweep:**
  - stimulus: `DIGIT_CYCLES` = 4, drive all nibble values 0–15 on digit 0;
  - required: `cathode_n` matches the table above; values 10–15 give 8'hFF.
- **Live update:**
  - stimulus: change `bcd_ip[3:0]` from 8 to 1 while digit 0 is lit;
  - required: `cathode_n` goes 8'h80 → 8'hF9 one cycle later; `anode_n` is unchanged.
- **Mid-scan reset:**
  - stimulus: assert `reset` while digit 2 is lit, then release;
  - required: outputs go dark, then resume at digit 0 for a full `DIGIT_CYCLES`.
- **One-cold check:**
  - stimulus: run any scan outside reset;
  - required: `anode_n` always has exactly one zero bit; `cathode_n[7]` = 1 always.
